// File: rtl/render_shape_sequencer.sv
// Raster timing and shape-table controller for the render_shape rasterizer bank.
// Generates frame/line strobes, double-buffers the shape table and resolves the front-most hit.
module render_shape_sequencer #(
    parameter int NUM_SHAPES = 7,
    parameter int H_ACTIVE   = 640,
    parameter int H_TOTAL    = 800,
    parameter int V_ACTIVE   = 480,
    parameter int V_TOTAL    = 525,
    parameter int INT_BITS   = 16,
    parameter int FLOAT_BITS = 32
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             wr_en,
    output logic                             wr_ready,
    input  logic [$clog2(NUM_SHAPES)-1:0]    wr_idx,
    input  logic [2:0]                       wr_field,
    input  logic [FLOAT_BITS-1:0]            wr_data,
    input  logic                             commit_req,
    output logic                             commit_done,
    output logic                             newframe,
    output logic                             newline,
    output logic [NUM_SHAPES*INT_BITS-1:0]   shp_ty,
    output logic [NUM_SHAPES*INT_BITS-1:0]   shp_size,
    output logic [NUM_SHAPES*FLOAT_BITS-1:0] shp_sin,
    output logic [NUM_SHAPES*FLOAT_BITS-1:0] shp_cos,
    output logic [NUM_SHAPES*FLOAT_BITS-1:0] shp_ix,
    output logic [NUM_SHAPES*FLOAT_BITS-1:0] shp_iy,
    input  logic [NUM_SHAPES-1:0]            hit,
    output logic                             pix_valid,
    output logic [INT_BITS-1:0]              pix_x,
    output logic [INT_BITS-1:0]              pix_y,
    output logic [$clog2(NUM_SHAPES+1)-1:0]  pix_shape
);

    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int IDX_W   = $clog2(NUM_SHAPES);
    localparam int SHAPE_W = $clog2(NUM_SHAPES + 1);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] PENDING = 2'd1;
    localparam logic [1:0] DONE    = 2'd2;

    logic [HW-1:0] hcnt;
    logic [VW-1:0] vcnt;
    logic          h_last;
    logic          v_last;
    logic          active;

    assign h_last   = (hcnt == HW'(H_TOTAL - 1));
    assign v_last   = (vcnt == VW'(V_TOTAL - 1));
    assign active   = (hcnt < HW'(H_ACTIVE)) && (vcnt < VW'(V_ACTIVE));
    assign newframe = h_last && v_last;
    // No strobe after the last active line: the frame strobe re-seeds row 0 instead.
    assign newline  = h_last && (vcnt < VW'(V_ACTIVE - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (h_last) begin
            hcnt <= '0;
            vcnt <= v_last ? '0 : vcnt + 1'b1;
        end else begin
            hcnt <= hcnt + 1'b1;
        end
    end

    logic [1:0] state;
    logic [1:0] state_next;
    logic       swap;
    logic       wr_accept;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (commit_req) state_next = PENDING;
            PENDING: if (newframe)   state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    assign wr_ready    = (state == IDLE);
    assign commit_done = (state == DONE);
    assign swap        = (state == PENDING) && newframe;
    assign wr_accept   = wr_en && wr_ready;

    // Writes only land in IDLE and swaps only in PENDING, so they never collide.
    generate
        for (genvar gi = 0; gi < NUM_SHAPES; gi++) begin : gen_slot
            logic                  sel;
            logic [INT_BITS-1:0]   sh_ty, sh_size, lv_ty, lv_size;
            logic [FLOAT_BITS-1:0] sh_sin, sh_cos, sh_ix, sh_iy;
            logic [FLOAT_BITS-1:0] lv_sin, lv_cos, lv_ix, lv_iy;

            assign sel = wr_accept && (wr_idx == IDX_W'(gi));

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    sh_ty   <= '0;
                    sh_size <= '0;
                    sh_sin  <= '0;
                    sh_cos  <= '0;
                    sh_ix   <= '0;
                    sh_iy   <= '0;
                    lv_ty   <= '0;
                    lv_size <= '0;
                    lv_sin  <= '0;
                    lv_cos  <= '0;
                    lv_ix   <= '0;
                    lv_iy   <= '0;
                end else begin
                    if (sel) begin
                        case (wr_field)
                            3'd0:    sh_ty   <= wr_data[INT_BITS-1:0];
                            3'd1:    sh_size <= wr_data[INT_BITS-1:0];
                            3'd2:    sh_sin  <= wr_data;
                            3'd3:    sh_cos  <= wr_data;
                            3'd4:    sh_ix   <= wr_data;
                            3'd5:    sh_iy   <= wr_data;
                            default: ;
                        endcase
                    end
                    if (swap) begin
                        lv_ty   <= sh_ty;
                        lv_size <= sh_size;
                        lv_sin  <= sh_sin;
                        lv_cos  <= sh_cos;
                        lv_ix   <= sh_ix;
                        lv_iy   <= sh_iy;
                    end
                end
            end

            assign shp_ty  [gi*INT_BITS   +: INT_BITS]   = lv_ty;
            assign shp_size[gi*INT_BITS   +: INT_BITS]   = lv_size;
            assign shp_sin [gi*FLOAT_BITS +: FLOAT_BITS] = lv_sin;
            assign shp_cos [gi*FLOAT_BITS +: FLOAT_BITS] = lv_cos;
            assign shp_ix  [gi*FLOAT_BITS +: FLOAT_BITS] = lv_ix;
            assign shp_iy  [gi*FLOAT_BITS +: FLOAT_BITS] = lv_iy;
        end
    endgenerate

    logic [SHAPE_W-1:0] first_hit;

    always_comb begin
        first_hit = SHAPE_W'(NUM_SHAPES);
        for (int i = NUM_SHAPES - 1; i >= 0; i--) begin
            if (hit[i]) first_hit = SHAPE_W'(i);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pix_valid <= 1'b0;
            pix_x     <= '0;
            pix_y     <= '0;
            pix_shape <= '0;
        end else begin
            pix_valid <= active;
            pix_x     <= INT_BITS'(hcnt);
            pix_y     <= INT_BITS'(vcnt);
            pix_shape <= active ? first_hit : SHAPE_W'(NUM_SHAPES);
        end
    end

endmodule
